// File: rtl/ddr_axi_read_ctrl.sv
// AXI4 read master for the DDR path: turns one UI read command into a sequence of
// INCR bursts, keeps up to MAX_OUTSTANDING bursts in flight, and writes returned beats to the UI FIFO.
module ddr_axi_read_ctrl #(
   parameter int         DATA_WIDTH      = 64,
   parameter int         ADDR_WIDTH      = 29,
   parameter int         BURST_LEN_WIDTH = 8,
   parameter int         NUM_BURST_WIDTH = 8,
   parameter int         MAX_OUTSTANDING = 4,
   parameter logic [3:0] AXI_ID          = 4'hF
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic                       rd_start,
   input  logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
   input  logic [ADDR_WIDTH-1:0]      rd_start_addr,
   input  logic [NUM_BURST_WIDTH-1:0] rd_num_burst,
   output logic                       rd_ready,
   input  logic                       rd_fifo_full,
   output logic [DATA_WIDTH-1:0]      rd_fifo_data,
   output logic                       rd_fifo_we,
   output logic                       rd_done,
   output logic                       rd_err,
   output logic [3:0]                 m_axi_arid,
   output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
   output logic [BURST_LEN_WIDTH-1:0] m_axi_arlen,
   output logic [2:0]                 m_axi_arsize,
   output logic [1:0]                 m_axi_arburst,
   output logic                       m_axi_arlock,
   output logic [3:0]                 m_axi_arcache,
   output logic [2:0]                 m_axi_arprot,
   output logic [3:0]                 m_axi_arqos,
   output logic                       m_axi_arvalid,
   input  logic                       m_axi_arready,
   output logic                       m_axi_rready,
   input  logic                       m_axi_rvalid,
   input  logic                       m_axi_rlast,
   input  logic [1:0]                 m_axi_rresp,
   input  logic [3:0]                 m_axi_rid,
   input  logic [DATA_WIDTH-1:0]      m_axi_rdata
);

   localparam int ARSIZE = $clog2(DATA_WIDTH / 8);
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e                     state_q, state_d;
   logic [ADDR_WIDTH-1:0]      araddr_q, araddr_d;
   logic [BURST_LEN_WIDTH-1:0] arlen_q, arlen_d;
   logic [BURST_LEN_WIDTH-1:0] burst_len_q, burst_len_d;
   logic [BURST_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [NUM_BURST_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
   logic [NUM_BURST_WIDTH-1:0] cmpl_cnt_q, cmpl_cnt_d;
   logic [OUT_W-1:0]           outstanding_q, outstanding_d;
   logic                       err_q, err_d;

   logic                  can_issue, ar_hs, r_hs, r_active, burst_end, out_dec;
   logic [ADDR_WIDTH-1:0] addr_step;

   assign m_axi_arid    = AXI_ID;
   assign m_axi_arsize  = 3'(ARSIZE);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;

   // FIFO side is a straight pass-through of the R channel
   assign m_axi_rready = ~rd_fifo_full;
   assign r_hs         = m_axi_rvalid & m_axi_rready;
   assign rd_fifo_we   = r_hs;
   assign rd_fifo_data = m_axi_rdata;

   // arvalid derives only from registered state, so it cannot drop before arready
   assign can_issue     = (state_q == ISSUE) && (issue_cnt_q != '0) &&
                          (outstanding_q < OUT_W'(MAX_OUTSTANDING));
   assign m_axi_arvalid = can_issue;
   assign ar_hs         = can_issue & m_axi_arready;

   // beats are only accounted while a command owns the bus; stale beats after reset just pass through
   assign r_active  = (state_q == ISSUE) || (state_q == DRAIN);
   assign burst_end = r_active & r_hs & (m_axi_rlast | (beat_cnt_q == arlen_q));
   assign out_dec   = burst_end && (outstanding_q != '0);
   assign addr_step = ADDR_WIDTH'(burst_len_q) << ARSIZE;

   assign rd_ready = (state_q == IDLE);
   assign rd_done  = (state_q == DONE);
   assign rd_err   = err_q;

   always_comb begin
      state_d       = state_q;
      araddr_d      = araddr_q;
      arlen_d       = arlen_q;
      burst_len_d   = burst_len_q;
      beat_cnt_d    = beat_cnt_q;
      issue_cnt_d   = issue_cnt_q;
      cmpl_cnt_d    = cmpl_cnt_q;
      outstanding_d = outstanding_q;
      err_d         = err_q;

      if (ar_hs) begin
         araddr_d    = araddr_q + addr_step;
         issue_cnt_d = issue_cnt_q - 1'b1;
      end

      case ({ar_hs, out_dec})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase

      if (r_active && r_hs) begin
         beat_cnt_d = burst_end ? '0 : beat_cnt_q + 1'b1;
         if ((m_axi_rresp != 2'b00) || (m_axi_rid != AXI_ID) ||
             (m_axi_rlast != (beat_cnt_q == arlen_q)))
            err_d = 1'b1;
      end
      if (burst_end && (cmpl_cnt_q != '0))
         cmpl_cnt_d = cmpl_cnt_q - 1'b1;

      case (state_q)
         IDLE: begin
            if (rd_start && (rd_burst_len != '0) && (rd_num_burst != '0)) begin
               araddr_d      = rd_start_addr;
               arlen_d       = rd_burst_len - 1'b1;
               burst_len_d   = rd_burst_len;
               beat_cnt_d    = '0;
               issue_cnt_d   = rd_num_burst;
               cmpl_cnt_d    = rd_num_burst;
               outstanding_d = '0;
               err_d         = 1'b0;
               state_d       = ISSUE;
            end
         end
         ISSUE:   if (issue_cnt_d == '0) state_d = DRAIN;
         DRAIN:   if (cmpl_cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q       <= IDLE;
         araddr_q      <= '0;
         arlen_q       <= '0;
         burst_len_q   <= '0;
         beat_cnt_q    <= '0;
         issue_cnt_q   <= '0;
         cmpl_cnt_q    <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         araddr_q      <= araddr_d;
         arlen_q       <= arlen_d;
         burst_len_q   <= burst_len_d;
         beat_cnt_q    <= beat_cnt_d;
         issue_cnt_q   <= issue_cnt_d;
         cmpl_cnt_q    <= cmpl_cnt_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

endmodule

// File: tb/tb_ddr_axi_read_ctrl.sv
// Bench for ddr_axi_read_ctrl: directed commands push expected ARs, beats and completions into
// queues; an AXI slave model answers the bus and a negedge monitor pops and compares.
module tb_ddr_axi_read_ctrl;
   localparam int DW = 64, AW = 29, LW = 8, NW = 8, MAXO = 4;

   logic          ACLK = 1'b0, ARESETN = 1'b0;
   logic          rd_start = 1'b0;
   logic [LW-1:0] rd_burst_len = '0;
   logic [AW-1:0] rd_start_addr = '0;
   logic [NW-1:0] rd_num_burst = '0;
   logic          rd_ready, rd_fifo_full = 1'b0, rd_fifo_we, rd_done, rd_err;
   logic [DW-1:0] rd_fifo_data;
   logic [3:0]    m_axi_arid, m_axi_arcache, m_axi_arqos;
   logic [AW-1:0] m_axi_araddr;
   logic [LW-1:0] m_axi_arlen;
   logic [2:0]    m_axi_arsize, m_axi_arprot;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arlock, m_axi_arvalid, m_axi_rready;
   logic          m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
   logic [1:0]    m_axi_rresp = 2'b00;
   logic [3:0]    m_axi_rid = 4'hF;
   logic [DW-1:0] m_axi_rdata = '0;

   ddr_axi_read_ctrl dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .rd_start(rd_start), .rd_burst_len(rd_burst_len),
      .rd_start_addr(rd_start_addr), .rd_num_burst(rd_num_burst), .rd_ready(rd_ready),
      .rd_fifo_full(rd_fifo_full), .rd_fifo_data(rd_fifo_data), .rd_fifo_we(rd_fifo_we),
      .rd_done(rd_done), .rd_err(rd_err), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
      .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rready(m_axi_rready), .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
      .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
   } ar_t;

   ar_t           exp_ar[$];
   logic [DW-1:0] exp_data[$];
   logic          exp_done[$];
   int n_chk = 0, n_fail = 0, done_cnt = 0, ar_total = 0, we_total = 0;

   // slave knobs
   int            r_hold = 0, ar_delay = 0, slverr_beat = -1, early_beat = -1;
   logic          inj_en = 1'b0;
   logic [AW-1:0] inj_addr = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] dat(input logic [AW-1:0] a, input int b);
      logic [7:0] bb;
      bb = b[7:0];
      return {3'b000, a, 16'hC0DE, 8'h00, bb};
   endfunction

   // monitor / scoreboard
   logic          active = 1'b0, pend = 1'b0;
   int            cmd_num = 0, issued = 0, completed = 0, cyc = 0, last_rl = 0;
   logic [AW-1:0] pend_addr = '0;
   logic [LW-1:0] pend_len = '0;
   ar_t           ea;
   logic [DW-1:0] ed;
   logic          ee;

   always @(negedge ACLK) begin
      cyc++;
      if (!ARESETN) begin
         exp_ar.delete(); exp_data.delete(); exp_done.delete();
         active = 1'b0; issued = 0; completed = 0; pend = 1'b0;
      end else begin
         chk("arvalid", 64'(m_axi_arvalid),
             64'(active && (issued < cmd_num) && ((issued - completed) < MAXO)));
         if (pend) begin
            chk("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
            chk("ar_hold_addr", 64'(m_axi_araddr), 64'(pend_addr));
            chk("ar_hold_len", 64'(m_axi_arlen), 64'(pend_len));
         end
         pend = m_axi_arvalid && !m_axi_arready;
         pend_addr = m_axi_araddr;
         pend_len = m_axi_arlen;
         if (m_axi_arvalid && m_axi_arready) begin
            ar_total++; issued++;
            chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
            if (exp_ar.size() != 0) begin
               ea = exp_ar.pop_front();
               chk("araddr", 64'(m_axi_araddr), 64'(ea.addr));
               chk("arlen", 64'(m_axi_arlen), 64'(ea.len));
            end
         end
         if (rd_fifo_we) begin
            we_total++;
            chk("data_expected", 64'(exp_data.size() != 0), 64'd1);
            if (exp_data.size() != 0) begin
               ed = exp_data.pop_front();
               chk("fifo_data", rd_fifo_data, ed);
            end
            if (m_axi_rlast) begin completed++; last_rl = cyc; end
         end
         if (rd_done) begin
            done_cnt++;
            chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
            if (exp_done.size() != 0) begin
               ee = exp_done.pop_front();
               chk("rd_err_at_done", 64'(rd_err), 64'(ee));
            end
            chk("done_latency", 64'(cyc - last_rl), 64'd2);
            active = 1'b0;
         end
         if (rd_start && rd_ready && rd_burst_len != 0 && rd_num_burst != 0) begin
            active = 1'b1; cmd_num = int'(rd_num_burst); issued = 0; completed = 0;
         end
      end
   end

   // AXI slave model: accepts ARs, returns beats in order, optional error injection on one burst
   ar_t sq[$];
   int  sbeat = 0, ar_wait = 0;
   logic hit;

   always begin
      @(negedge ACLK);
      if (!ARESETN) begin
         sq.delete(); sbeat = 0; ar_wait = 0;
      end else begin
         if (m_axi_arvalid && m_axi_arready) begin
            sq.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
            ar_wait = 0;
         end else if (m_axi_arvalid) ar_wait++;
         if (m_axi_rvalid && m_axi_rready) begin
            if (m_axi_rlast) begin void'(sq.pop_front()); sbeat = 0; end
            else sbeat++;
         end
      end
      @(posedge ACLK);
      #1;
      m_axi_arready = (ar_wait >= ar_delay);
      if (r_hold == 0 && sq.size() > 0) begin
         hit          = inj_en && (sq[0].addr == inj_addr);
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = dat(sq[0].addr, sbeat);
         m_axi_rlast  = (sbeat == int'(sq[0].len)) || (hit && sbeat == early_beat);
         m_axi_rresp  = (hit && sbeat == slverr_beat) ? 2'b10 : 2'b00;
      end else begin
         m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic push_cmd(input logic [AW-1:0] addr, input int len, input int num,
                           input int early_b, input logic err);
      logic [AW-1:0] a;
      int nb;
      for (int b = 0; b < num; b++) begin
         a = addr + AW'(b * len * 8);
         exp_ar.push_back('{addr: a, len: LW'(len - 1)});
         nb = (b == early_b) ? early_beat + 1 : len;
         for (int i = 0; i < nb; i++) exp_data.push_back(dat(a, i));
      end
      exp_done.push_back(err);
   endtask

   task automatic start_cmd(input logic [AW-1:0] addr, input int len, input int num);
      tick();
      rd_start = 1'b1; rd_start_addr = addr; rd_burst_len = LW'(len); rd_num_burst = NW'(num);
      tick();
      rd_start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int max);
      int d0, n;
      d0 = done_cnt; n = 0;
      while (done_cnt == d0 && n < max) begin tick(); n++; end
      chk(nm, 64'(done_cnt != d0), 64'd1);
   endtask

   int base, n, w0;

   initial begin
      // reset state
      ARESETN = 1'b0;
      repeat (3) tick();
      chk("rst_rd_ready", 64'(rd_ready), 64'd1);
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst_done", 64'(rd_done), 64'd0);
      chk("rst_err", 64'(rd_err), 64'd0);
      chk("rst_araddr", 64'(m_axi_araddr), 64'd0);
      chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
      chk("arid", 64'(m_axi_arid), 64'hF);
      chk("arsize", 64'(m_axi_arsize), 64'd3);
      chk("arburst", 64'(m_axi_arburst), 64'd1);
      chk("arlock", 64'(m_axi_arlock), 64'd0);
      chk("arcache", 64'(m_axi_arcache), 64'd3);
      chk("arprot", 64'(m_axi_arprot), 64'd0);
      chk("arqos", 64'(m_axi_arqos), 64'd0);
      ARESETN = 1'b1;
      tick();

      // single burst
      push_cmd(29'h1000, 16, 1, -1, 1'b0);
      start_cmd(29'h1000, 16, 1);
      wait_done("t1_done", 200);
      chk("t1_err", 64'(rd_err), 64'd0);

      // pipelining limited by outstanding bursts while R is withheld
      r_hold = 1;
      base = ar_total;
      push_cmd(29'h0, 8, 6, -1, 1'b0);
      start_cmd(29'h0, 8, 6);
      repeat (20) tick();
      chk("t2_ar_in_flight", 64'(ar_total - base), 64'd4);
      r_hold = 0;
      wait_done("t2_done", 500);
      chk("t2_ar_total", 64'(ar_total - base), 64'd6);

      // FIFO backpressure mid-burst
      push_cmd(29'h2000, 16, 1, -1, 1'b0);
      start_cmd(29'h2000, 16, 1);
      base = we_total; n = 0;
      while (we_total < base + 5 && n < 100) begin tick(); n++; end
      rd_fifo_full = 1'b1;
      w0 = we_total;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t3_rready", 64'(m_axi_rready), 64'd0);
         chk("t3_we", 64'(rd_fifo_we), 64'd0);
         tick();
      end
      chk("t3_we_frozen", 64'(we_total), 64'(w0));
      rd_fifo_full = 1'b0;
      wait_done("t3_done", 200);

      // SLVERR on beat 3, then cleared by the next command
      inj_en = 1'b1; inj_addr = 29'h3000; slverr_beat = 2;
      push_cmd(29'h3000, 8, 1, -1, 1'b1);
      start_cmd(29'h3000, 8, 1);
      wait_done("t4a_done", 200);
      chk("t4a_err_sticky", 64'(rd_err), 64'd1);
      inj_en = 1'b0; slverr_beat = -1;
      push_cmd(29'h3400, 4, 1, -1, 1'b0);
      start_cmd(29'h3400, 4, 1);
      chk("t4a_err_cleared", 64'(rd_err), 64'd0);
      wait_done("t4a2_done", 200);

      // early rlast on beat 6 of 8 in the first of two bursts
      inj_en = 1'b1; inj_addr = 29'h4000; early_beat = 5;
      push_cmd(29'h4000, 8, 2, 0, 1'b1);
      start_cmd(29'h4000, 8, 2);
      wait_done("t4b_done", 300);
      inj_en = 1'b0; early_beat = -1;

      // single-beat bursts: AR handshakes coincide with rlast
      push_cmd(29'h5000, 1, 8, -1, 1'b0);
      start_cmd(29'h5000, 1, 8);
      wait_done("t5a_done", 300);

      // arready delayed 3 cycles per request
      ar_delay = 3;
      push_cmd(29'h6000, 4, 2, -1, 1'b0);
      start_cmd(29'h6000, 4, 2);
      wait_done("t5b_done", 300);
      ar_delay = 0;

      // zero count / zero length commands are ignored
      start_cmd(29'h7000, 4, 0);
      for (int k = 0; k < 3; k++) begin
         chk("t5c_ready", 64'(rd_ready), 64'd1);
         chk("t5c_arvalid", 64'(m_axi_arvalid), 64'd0);
         tick();
      end
      start_cmd(29'h7000, 0, 3);
      chk("t5c_ready_len0", 64'(rd_ready), 64'd1);
      repeat (3) tick();

      // reset while draining
      r_hold = 1;
      base = ar_total; w0 = done_cnt; n = 0;
      push_cmd(29'h8000, 4, 2, -1, 1'b0);
      start_cmd(29'h8000, 4, 2);
      while (ar_total < base + 2 && n < 50) begin tick(); n++; end
      chk("t6_ars", 64'(ar_total - base), 64'd2);
      repeat (2) tick();
      chk("t6_busy", 64'(rd_ready), 64'd0);
      ARESETN = 1'b0;
      tick();
      ARESETN = 1'b1;
      chk("t6_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("t6_ready", 64'(rd_ready), 64'd1);
      chk("t6_err", 64'(rd_err), 64'd0);
      chk("t6_no_done", 64'(rd_done), 64'd0);
      r_hold = 0;
      repeat (10) tick();
      chk("t6_no_done_cnt", 64'(done_cnt), 64'(w0));

      // recovery after reset
      push_cmd(29'h9000, 2, 3, -1, 1'b0);
      start_cmd(29'h9000, 2, 3);
      wait_done("t7_done", 200);
      chk("end_ar_left", 64'(exp_ar.size()), 64'd0);
      chk("end_data_left", 64'(exp_data.size()), 64'd0);
      chk("end_done_left", 64'(exp_done.size()), 64'd0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_chk - n_fail, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/ddr_axi_read_ctrl.md
Name: ddr_axi_read_ctrl

Overview:
Parametrised AXI4 read master for the DDR path. It turns one UI read command (start address, burst length, burst count) into a stream of AR requests and pushes the returned data into the UI read FIFO. It keeps up to MAX_OUTSTANDING bursts in flight and honours FIFO backpressure through RREADY. It checks beat count and RRESP per burst and reports a sticky error per command. It sits between the UI read FIFO and the AXI interconnect / MIG slave port.

Parameters:
DATA_WIDTH, 64, AXI data width in bits; power of two, 8..1024; ARSIZE = log2(DATA_WIDTH/8).
ADDR_WIDTH, 29, AXI byte address width.
BURST_LEN_WIDTH, 8, width of rd_burst_len and ARLEN.
NUM_BURST_WIDTH, 8, width of rd_num_burst.
MAX_OUTSTANDING, 4, maximum accepted-but-incomplete bursts; 1..16.
AXI_ID, 4'hF, constant ARID.

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
rd_start  in  1  command strobe, accepted only when rd_ready=1
rd_burst_len  in  BURST_LEN_WIDTH  beats per burst (1..2^BURST_LEN_WIDTH-1)
rd_start_addr  in  ADDR_WIDTH  byte address of the first burst
rd_num_burst  in  NUM_BURST_WIDTH  number of bursts
rd_ready  out  1  idle, command can be accepted
rd_fifo_full  in  1  UI FIFO full
rd_fifo_data  out  DATA_WIDTH  = m_axi_rdata
rd_fifo_we  out  1  = m_axi_rvalid & m_axi_rready
rd_done  out  1  one-cycle pulse at command completion
rd_err  out  1  sticky error for the current/last command
m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  out  4/ADDR_WIDTH/BURST_LEN_WIDTH/3/2/1/4/3/4  AR channel
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rready  out  1  = ~rd_fifo_full
m_axi_rvalid, m_axi_rlast  in  1, 1  R channel
m_axi_rresp, m_axi_rid, m_axi_rdata  in  2, 4, DATA_WIDTH  R channel

Behaviour:
- Constants: arid=AXI_ID, arsize=log2(DATA_WIDTH/8), arburst=INCR, arlock=0, arcache=4'b0011, arprot=0, arqos=0.
- Reset (ARESETN=0 at a rising edge), including mid-command: state IDLE, arvalid=0, araddr=0, arlen=0, all counters=0, rd_err=0, rd_done=0. rd_ready=1 from the first cycle after reset. In-flight R beats arriving after reset still produce rd_fifo_we when rready=1.
- States:
  - IDLE: on rd_start with rd_burst_len!=0 and rd_num_burst!=0, latch araddr=rd_start_addr, arlen=rd_burst_len-1, issue_cnt=rd_num_burst, cmpl_cnt=rd_num_burst, outstanding=0; clear rd_err; go to ISSUE. rd_start with a zero length or zero count is ignored, and the block stays in IDLE.
  - ISSUE: arvalid=1 while issue_cnt>0 and outstanding<MAX_OUTSTANDING. Once asserted, arvalid holds with stable araddr/arlen until arready (AXI rule).
  - On each AR handshake: issue_cnt-1, outstanding+1, araddr += rd_burst_len<<arsize (modulo 2^ADDR_WIDTH). The next request may assert on the following cycle; back-to-back handshakes are allowed.
  - When issue_cnt reaches 0, go to DRAIN. DRAIN waits for cmpl_cnt==0, then goes to DONE.
  - DONE: rd_done=1 for exactly one cycle, then IDLE.
- R channel, per beat with rvalid&rready: beat_cnt+1. On rlast: cmpl_cnt-1, outstanding-1, beat_cnt=0.
- AR handshake and rlast in the same cycle: outstanding is unchanged; both counters still update.
- rd_err sets, and holds until the next accepted command, when any of these occurs:
  - rresp!=OKAY on any beat;
  - rid!=AXI_ID;
  - rlast at beat_cnt!=arlen;
  - no rlast at beat_cnt==arlen.
- A missing rlast still ends the burst (counted as complete) so the command terminates.
- The block does not split bursts at 4 KB boundaries. The caller guarantees rd_start_addr and rd_burst_len keep each burst within 4 KB.
- rd_fifo_data and rd_fifo_we are combinational from the R channel. No added latency.

Test Plan:
1. Single burst: addr 0x1000, len 16, num 1, arready=1, fifo never full -> one AR (araddr 0x1000, arlen 15), 16 fifo_we, rd_done pulses 1 cycle after rlast+1, rd_err=0.
2. Multi-burst pipelining: len 8, num 6, MAX_OUTSTANDING=4, slave withholds R -> exactly 4 ARs at 0x0,0x40,0x80,0xC0. After the first rlast, the fifth AR at 0x100 is issued. 48 writes total.
3. Backpressure: rd_fifo_full high for 5 cycles mid-burst -> rready=0 for those cycles, no fifo_we, beat count correct, data order preserved.
4. Errors: rresp=SLVERR on beat 3 -> rd_err=1 through rd_done, cleared on the next accepted rd_start. Early rlast on beat 6 of 8 -> rd_err=1, and the command still completes.
5. Edge cases: AR handshake and rlast in the same cycle -> outstanding stays constant. arready delayed 3 cycles -> arvalid and araddr stable. rd_start with num=0 -> ignored, rd_ready stays 1.
6. Reset mid-DRAIN: ARESETN low for 1 edge -> arvalid=0, rd_ready=1 next cycle, no rd_done, rd_err=0.
